cmd_issue_seq: RTL and testbench

//  Synthesizable initiator for the commit unit's req/rsp command interface; replaces the bench-driven issue loop.

---
 rtl/cmd_issue_seq.sv | 154 +++++++++++++++
 tb/tb_cmd_issue_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_seq.sv
// Command issue sequencer: replays a small program RAM of 32-bit command words
// to the commit unit over req/rsp handshakes, one outstanding command at a time.
module cmd_issue_seq #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic [AW:0]   cmd_num,
  input  logic          start,
  output logic          req_vaild,
  input  logic          req_ready,
  output logic [31:0]   r_in,
  input  logic          rsp_vaild,
  output logic          rsp_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   issued_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_REQ,
    WAIT_RSP,
    NEXT
  } state_t;

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW:0]   num_q;
  logic [TW-1:0] tmo_q;
  logic          req_vaild_q;
  logic          rsp_ready_q;
  logic [31:0]   r_in_q;
  logic          done_q;
  logic          err_q;
  logic [AW:0]   issued_q;

  logic [31:0]   mem [DEPTH];

  logic          prog_wr_d;
  logic [AW:0]   num_d;
  logic          tmo_hit_d;
  logic          last_d;

  always_comb begin
    prog_wr_d = (state_q == IDLE) && prog_we && !start;
    num_d     = (cmd_num > DEPTH_W) ? DEPTH_W : cmd_num;
    tmo_hit_d = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    last_d    = ({1'b0, ptr_q} == (num_q - (AW+1)'(1)));
  end

  // Program RAM has no reset; contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (prog_wr_d) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      num_q       <= '0;
      tmo_q       <= '0;
      req_vaild_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      r_in_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      issued_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
            if (cmd_num == '0) begin
              done_q <= 1'b1;
            end else begin
              num_q    <= num_d;
              ptr_q    <= '0;
              issued_q <= '0;
              state_q  <= LOAD;
            end
          end
        end
        LOAD: begin
          r_in_q      <= mem[ptr_q];
          req_vaild_q <= 1'b1;
          tmo_q       <= '0;
          state_q     <= WAIT_REQ;
        end
        WAIT_REQ: begin
          // A transfer on the same edge as the timeout wins.
          if (req_vaild_q && req_ready) begin
            req_vaild_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= WAIT_RSP;
          end else if (tmo_hit_d) begin
            err_q       <= 1'b1;
            req_vaild_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        WAIT_RSP: begin
          if (rsp_ready_q && rsp_vaild) begin
            rsp_ready_q <= 1'b0;
            issued_q    <= issued_q + (AW+1)'(1);
            state_q     <= NEXT;
          end else if (tmo_hit_d) begin
            err_q       <= 1'b1;
            req_vaild_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        NEXT: begin
          if (last_d) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            ptr_q   <= ptr_q + AW'(1);
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_vaild  = req_vaild_q;
  assign rsp_ready  = rsp_ready_q;
  assign r_in       = r_in_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_cmd_issue_seq.sv
// Directed bench for cmd_issue_seq: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_cmd_issue_seq;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [AW:0]   cmd_num;
  logic          start;
  logic          req_vaild;
  logic          req_ready;
  logic [31:0]   r_in;
  logic          rsp_vaild;
  logic          rsp_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   issued_cnt;

  int vectors = 0;
  int errs    = 0;
  int cyc       = 0;
  int xfer_cnt  = 0;
  int xfer_prev = 0;
  int xfer_last = 0;
  int done_cnt  = 0;

  cmd_issue_seq #(.DEPTH(32), .AW(AW), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .cmd_num    (cmd_num),
    .start      (start),
    .req_vaild  (req_vaild),
    .req_ready  (req_ready),
    .r_in       (r_in),
    .rsp_vaild  (rsp_vaild),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (req_vaild && req_ready) begin
      xfer_cnt++;
      xfer_prev = xfer_last;
      xfer_last = cyc;
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_word(input logic [AW-1:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    cmd_num = '0; start = 1'b0; req_ready = 1'b0; rsp_vaild = 1'b0;
    step(); step();
    vectors++; if ({req_vaild, rsp_ready, busy, done, err} !== 5'b0) begin errs++; $display("FAIL reset_ctrl got=%b exp=00000", {req_vaild, rsp_ready, busy, done, err}); end
    vectors++; if (r_in !== 32'h0) begin errs++; $display("FAIL reset_r_in got=%h exp=00000000", r_in); end
    vectors++; if (issued_cnt !== '0) begin errs++; $display("FAIL reset_issued got=%0d exp=0", issued_cnt); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] exp_w [3];
    int n, x0, d0;
    exp_w[0] = 32'h0A952A0B; exp_w[1] = 32'h0400010B; exp_w[2] = 32'h1000010B;
    for (int i = 0; i < 3; i++) prog_word(AW'(i), exp_w[i]);
    x0 = xfer_cnt; d0 = done_cnt;
    cmd_num = 6'd3; start = 1'b1; req_ready = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy got=%b exp=1", busy); end
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (req_vaild !== 1'b1 && n < 10) begin step(); n++; end
      vectors++; if (req_vaild !== 1'b1) begin errs++; $display("FAIL basic_req_vld[%0d] got=%b exp=1", i, req_vaild); end
      vectors++; if (r_in !== exp_w[i]) begin errs++; $display("FAIL basic_r_in[%0d] got=%h exp=%h", i, r_in, exp_w[i]); end
      step();
      vectors++; if ({req_vaild, rsp_ready} !== 2'b01) begin errs++; $display("FAIL basic_hs[%0d] got=%b exp=01", i, {req_vaild, rsp_ready}); end
      step(); step();
      rsp_vaild = 1'b1;
      step();
      rsp_vaild = 1'b0;
      vectors++; if (issued_cnt !== 6'(i + 1)) begin errs++; $display("FAIL basic_issued[%0d] got=%0d exp=%0d", i, issued_cnt, i + 1); end
    end
    step();
    vectors++; if (done !== 1'b1) begin errs++; $display("FAIL basic_done got=%b exp=1", done); end
    step();
    vectors++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
    vectors++; if (xfer_cnt - x0 !== 3) begin errs++; $display("FAIL basic_xfers got=%0d exp=3", xfer_cnt - x0); end
    vectors++; if ({busy, err} !== 2'b00) begin errs++; $display("FAIL basic_end_flags got=%b exp=00", {busy, err}); end
    req_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n, x0;
    req_ready = 1'b0; rsp_vaild = 1'b0;
    cmd_num = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    x0 = xfer_cnt;
    for (int k = 0; k < 5; k++) begin
      vectors++; if (req_vaild !== 1'b1) begin errs++; $display("FAIL bp_req_vld[%0d] got=%b exp=1", k, req_vaild); end
      vectors++; if (r_in !== 32'h0A952A0B) begin errs++; $display("FAIL bp_r_in[%0d] got=%h exp=0a952a0b", k, r_in); end
      step();
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    vectors++; if (xfer_cnt - x0 !== 1) begin errs++; $display("FAIL bp_one_xfer got=%0d exp=1", xfer_cnt - x0); end
    vectors++; if (rsp_ready !== 1'b1) begin errs++; $display("FAIL bp_rsp_ready got=%b exp=1", rsp_ready); end
    rsp_vaild = 1'b1;
    step();
    rsp_vaild = 1'b0;
    wait_done(4, n);
    vectors++; if (done !== 1'b1) begin errs++; $display("FAIL bp_done got=%b exp=1", done); end
    step();
    vectors++; if (xfer_cnt - x0 !== 1) begin errs++; $display("FAIL bp_xfer_total got=%0d exp=1", xfer_cnt - x0); end
  endtask

  task automatic test_rsp_early();
    int n;
    req_ready = 1'b1; rsp_vaild = 1'b1;
    cmd_num = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(20, n);
    vectors++; if (n !== 8) begin errs++; $display("FAIL early_cycles got=%0d exp=8", n); end
    vectors++; if (xfer_last - xfer_prev !== 4) begin errs++; $display("FAIL early_period got=%0d exp=4", xfer_last - xfer_prev); end
    vectors++; if (issued_cnt !== 6'd2) begin errs++; $display("FAIL early_issued got=%0d exp=2", issued_cnt); end
    req_ready = 1'b0; rsp_vaild = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int d0;
    req_ready = 1'b0; rsp_vaild = 1'b0;
    d0 = done_cnt;
    cmd_num = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (15) step();
    vectors++; if ({req_vaild, err} !== 2'b10) begin errs++; $display("FAIL tmo_cycle16 got=%b exp=10", {req_vaild, err}); end
    step();
    vectors++; if ({err, req_vaild, busy} !== 3'b100) begin errs++; $display("FAIL tmo_abort got=%b exp=100", {err, req_vaild, busy}); end
    vectors++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL tmo_no_done got=%0d exp=0", done_cnt - d0); end
    cmd_num = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if ({err, done} !== 2'b01) begin errs++; $display("FAIL tmo_err_clear got=%b exp=01", {err, done}); end
    step();
  endtask

  task automatic test_reset_midrun();
    int n;
    req_ready = 1'b1; rsp_vaild = 1'b0;
    cmd_num = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    vectors++; if (rsp_ready !== 1'b1) begin errs++; $display("FAIL rst_pre_rsp got=%b exp=1", rsp_ready); end
    #1 reset = 1'b0;
    #1;
    vectors++; if ({req_vaild, rsp_ready, busy, done, err} !== 5'b0) begin errs++; $display("FAIL rst_async got=%b exp=00000", {req_vaild, rsp_ready, busy, done, err}); end
    vectors++; if ({r_in, issued_cnt} !== '0) begin errs++; $display("FAIL rst_async_data got=%h/%0d exp=0/0", r_in, issued_cnt); end
    step();
    vectors++; if ({req_vaild, rsp_ready, busy} !== 3'b0) begin errs++; $display("FAIL rst_held got=%b exp=000", {req_vaild, rsp_ready, busy}); end
    reset = 1'b1; rsp_vaild = 1'b1;
    step();
    cmd_num = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++; if ({req_vaild, r_in} !== {1'b1, 32'h0A952A0B}) begin errs++; $display("FAIL rst_reissue got=%b/%h exp=1/0a952a0b", req_vaild, r_in); end
    wait_done(8, n);
    vectors++; if ({done, issued_cnt} !== {1'b1, 6'd1}) begin errs++; $display("FAIL rst_run_done got=%b/%0d exp=1/1", done, issued_cnt); end
    step();
    vectors++; if (r_in !== 32'h0A952A0B) begin errs++; $display("FAIL rst_r_in_hold got=%h exp=0a952a0b", r_in); end
    req_ready = 1'b0; rsp_vaild = 1'b0;
  endtask

  task automatic test_zero_and_priority();
    int n, x0;
    x0 = xfer_cnt;
    cmd_num = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if ({done, busy} !== 2'b10) begin errs++; $display("FAIL zero_done got=%b exp=10", {done, busy}); end
    step();
    vectors++; if (done !== 1'b0) begin errs++; $display("FAIL zero_pulse_width got=%b exp=0", done); end
    vectors++; if (xfer_cnt - x0 !== 0) begin errs++; $display("FAIL zero_no_req got=%0d exp=0", xfer_cnt - x0); end
    prog_we = 1'b1; prog_addr = '0; prog_data = 32'hDEADBEEF;
    cmd_num = 6'd1; start = 1'b1; req_ready = 1'b1; rsp_vaild = 1'b0;
    step();
    prog_we = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b1) begin errs++; $display("FAIL prio_started got=%b exp=1", busy); end
    step();
    vectors++; if (r_in !== 32'h0A952A0B) begin errs++; $display("FAIL prio_write_dropped got=%h exp=0a952a0b", r_in); end
    step();
    prog_we = 1'b1; prog_addr = '0; prog_data = 32'h11111111; rsp_vaild = 1'b1;
    step();
    prog_we = 1'b0; rsp_vaild = 1'b0;
    wait_done(4, n);
    step();
    cmd_num = 6'd1; start = 1'b1; rsp_vaild = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++; if (r_in !== 32'h0A952A0B) begin errs++; $display("FAIL busy_write_ignored got=%h exp=0a952a0b", r_in); end
    wait_done(6, n);
    step();
    req_ready = 1'b0; rsp_vaild = 1'b0;
  endtask

  task automatic test_clamp();
    int n;
    req_ready = 1'b1; rsp_vaild = 1'b1;
    cmd_num = 6'd40; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, n);
    vectors++; if (n !== 128) begin errs++; $display("FAIL clamp_cycles got=%0d exp=128", n); end
    vectors++; if ({issued_cnt, err} !== {6'd32, 1'b0}) begin errs++; $display("FAIL clamp_issued got=%0d/%b exp=32/0", issued_cnt, err); end
    req_ready = 1'b0; rsp_vaild = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_rsp_early();
    test_timeout();
    test_reset_midrun();
    test_zero_and_priority();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
